// File: rtl/dm_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: two requester ports (p0 = CPU,
// p1 = DMA/debug) plus the single downstream memory port.
// slave  : arbiter side (takes requests and mem_rd, drives grants and mem_*).
// master : requester/memory side, the mirror image.
interface dm_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              p0_req,   p1_req;
  logic              p0_we,    p1_we;
  logic              p0_lock,  p1_lock;
  logic [DATA_W-1:0] p0_addr,  p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt,   p1_gnt;
  logic              p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              mem_we,   mem_re;
  logic [DATA_W-1:0] mem_addr, mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rd,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    output mem_we, mem_re, mem_addr, mem_wd
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
    output p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rd,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    input  mem_we, mem_re, mem_addr, mem_wd
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port memory arbiter with locked bursts.
// Grants are combinational in the request cycle; read data is captured at the
// grant-cycle edge and presented with a one-cycle rvalid pulse.
// A locked owner keeps the port for at most MAX_BURST consecutive grants.
// Whenever ownership ends, the other port wins a conflict in the next cycle.
// Optional feature macro: DM_ARB_RR_EN -- round-robin on idle conflicts;
// when undefined, port0 has fixed priority on idle conflicts.
module dm_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef DM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;       // last granted port
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // grants so far in current burst
  logic [CNT_W-1:0]   cnt_inc;
  logic               yield_q, yield_d;   // ownership just ended: other port first
  logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [31:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic               gnt0, gnt1, prio1;

  // Port1 wins an idle conflict when round-robin says so, or right after an
  // ownership period so the waiting port is not starved by the old owner.
  assign prio1 = ~ptr_q & (RR_EN | yield_q);

  // Grant decision, suppressed during the reset cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.p0_req && bus.p1_req) begin
            gnt0 = ~prio1;
            gnt1 = prio1;
          end else begin
            gnt0 = bus.p0_req;
            gnt1 = bus.p1_req;
          end
        end
        OWN0:    gnt0 = bus.p0_req;
        OWN1:    gnt1 = bus.p1_req;
        default: ;
      endcase
    end
  end

  // Memory port mux: granted port passes through unmodified, zeros otherwise.
  assign bus.p0_gnt   = gnt0;
  assign bus.p1_gnt   = gnt1;
  assign bus.mem_we   = (gnt0 & bus.p0_we) | (gnt1 & bus.p1_we);
  assign bus.mem_re   = (gnt0 & ~bus.p0_we) | (gnt1 & ~bus.p1_we);
  assign bus.mem_addr = gnt0 ? bus.p0_addr  : (gnt1 ? bus.p1_addr  : 32'h0);
  assign bus.mem_wd   = gnt0 ? bus.p0_wdata : (gnt1 ? bus.p1_wdata : 32'h0);

  // A pending rvalid is dropped as soon as reset is seen.
  assign bus.p0_rvalid = rvalid0_q & ~reset;
  assign bus.p1_rvalid = rvalid1_q & ~reset;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

  // Next-state: ownership FSM, burst count, pointer and read capture.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    yield_d   = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    cnt_inc   = cnt_q + CNT_W'(1);

    if (gnt0 || gnt1) ptr_d = gnt1;
    if (gnt0 && !bus.p0_we) begin
      rvalid0_d = 1'b1;
      rdata0_d  = bus.mem_rd;
    end
    if (gnt1 && !bus.p1_we) begin
      rvalid1_d = 1'b1;
      rdata1_d  = bus.mem_rd;
    end

    case (state_q)
      IDLE: begin
        if ((gnt0 && bus.p0_lock) || (gnt1 && bus.p1_lock)) begin
          if (MAX_BURST > 1) begin
            state_d = gnt0 ? OWN0 : OWN1;
            cnt_d   = CNT_W'(1);
          end else begin
            yield_d = 1'b1;
          end
        end
      end
      OWN0: begin
        if (!bus.p0_req || !bus.p0_lock || cnt_inc >= CNT_W'(MAX_BURST)) begin
          state_d = IDLE;
          cnt_d   = '0;
          yield_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      OWN1: begin
        if (!bus.p1_req || !bus.p1_lock || cnt_inc >= CNT_W'(MAX_BURST)) begin
          state_d = IDLE;
          cnt_d   = '0;
          yield_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any burst and clears read status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      cnt_q     <= '0;
      yield_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      yield_q   <= yield_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter (MAX_BURST = 8) with a 16-word memory model.
// Expectations for idle conflicts follow the DM_ARB_RR_EN build setting.
module tb_dm_arbiter;

`ifdef DM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dm_arbiter_if #(.DATA_W(32)) bus ();

  dm_arbiter #(.MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, posedge write, filled on reset.
  logic [31:0] mem [16];
  assign bus.mem_rd = mem[bus.mem_addr[5:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_p0(input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
    bus.p0_req = r; bus.p0_we = w; bus.p0_lock = l; bus.p0_addr = a; bus.p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
    bus.p1_req = r; bus.p1_we = w; bus.p1_lock = l; bus.p1_addr = a; bus.p1_wdata = d;
  endtask

  // Cross the active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    #1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    set_p0(1, 0, 0, 32'h0, 0);
    set_p1(1, 0, 0, 32'h4, 0);

    // Reset cycle: requests present but nothing granted.
    #2;
    chk("rst_p0_gnt", bus.p0_gnt, 0);
    chk("rst_p1_gnt", bus.p1_gnt, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    tick();
    chk("rst_p0_rvalid", bus.p0_rvalid, 0);
    chk("rst_p0_rdata", bus.p0_rdata, 0);
    chk("rst_p1_rvalid", bus.p1_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    tick();

    // Both ports read every cycle for 4 cycles.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_p0(1, 0, 0, 32'h0, 0);
      set_p1(1, 0, 0, 32'h4, 0);
      #1;
      chk($sformatf("conf%0d_p0_gnt", c), bus.p0_gnt, RR ? ((c % 2) == 0) : 1'b1);
      chk($sformatf("conf%0d_p1_gnt", c), bus.p1_gnt, RR ? ((c % 2) == 1) : 1'b0);
      tick();
      if (c == 0) begin
        chk("conf0_p0_rvalid", bus.p0_rvalid, 1);
        chk("conf0_p0_rdata", bus.p0_rdata, 32'hA5A5_0000);
        chk("conf0_p1_rvalid", bus.p1_rvalid, 0);
      end
    end
    idle_cycle();

    // p0 write 0x10 then read it back.
    @(negedge clk);
    set_p0(1, 1, 0, 32'h10, 32'hDEADBEEF);
    #1;
    chk("wr_gnt", bus.p0_gnt, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_re", bus.mem_re, 0);
    chk("wr_mem_addr", bus.mem_addr, 32'h10);
    chk("wr_mem_wd", bus.mem_wd, 32'hDEADBEEF);
    tick();
    chk("wr_no_rvalid", bus.p0_rvalid, 0);
    @(negedge clk);
    set_p0(1, 0, 0, 32'h10, 0);
    #1;
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_mem_re", bus.mem_re, 1);
    tick();
    chk("rd_rvalid", bus.p0_rvalid, 1);
    chk("rd_rdata", bus.p0_rdata, 32'hDEADBEEF);
    idle_cycle();
    chk("rd_rvalid_pulse", bus.p0_rvalid, 0);
    chk("rd_rdata_hold", bus.p0_rdata, 32'hDEADBEEF);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_mem_wd", bus.mem_wd, 0);

    // p1 locked burst with p0 requesting: 8 p1 grants then p0.
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      set_p1(1, 0, 1, 32'hC, 0);
      if (c == 1) set_p0(0, 0, 0, 0, 0);
      else        set_p0(1, 0, 0, 32'h10, 0);
      #1;
      chk($sformatf("burst%0d_p1_gnt", c), bus.p1_gnt, c <= 8);
      chk($sformatf("burst%0d_p0_gnt", c), bus.p0_gnt, c == 9);
      tick();
      if (c == 1) begin
        chk("burst1_p1_rvalid", bus.p1_rvalid, 1);
        chk("burst1_p1_rdata", bus.p1_rdata, 32'hA5A5_0003);
      end
    end
    idle_cycle();

    // Single p1 write so p1 is the last-granted port.
    @(negedge clk);
    set_p1(1, 1, 0, 32'h20, 32'h1);
    #1;
    chk("p1wr_gnt", bus.p1_gnt, 1);
    chk("p1wr_mem_we", bus.mem_we, 1);
    chk("p1wr_mem_addr", bus.mem_addr, 32'h20);
    tick();
    idle_cycle();

    // p0 lock released after 3 grants while p1 requests: p1 gets cycle 4.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      set_p0(1, 1, c < 3, 32'h24, 32'h5);
      set_p1(1, 0, 0, 32'h8, 0);
      #1;
      chk($sformatf("rel%0d_p0_gnt", c), bus.p0_gnt, c <= 3);
      chk($sformatf("rel%0d_p1_gnt", c), bus.p1_gnt, c == 4);
      tick();
    end
    idle_cycle();

    // Reset in cycle 2 of a p1 locked read burst.
    @(negedge clk);
    set_p1(1, 0, 1, 32'h8, 0);
    #1;
    chk("rb1_p1_gnt", bus.p1_gnt, 1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rb2_p1_gnt", bus.p1_gnt, 0);
    chk("rb2_mem_re", bus.mem_re, 0);
    chk("rb2_p1_rvalid", bus.p1_rvalid, 0);
    tick();
    chk("rb3_p1_rvalid", bus.p1_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    set_p0(1, 0, 0, 32'h0, 0);
    set_p1(1, 0, 1, 32'h8, 0);
    #1;
    chk("rb3_p0_gnt", bus.p0_gnt, 1);
    chk("rb3_p1_gnt", bus.p1_gnt, 0);
    tick();
    chk("rb3_p0_rvalid", bus.p0_rvalid, 1);
    chk("rb3_p1_rvalid_after", bus.p1_rvalid, 0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
